bus_width_fifo: RTL and testbench
=================================

Name: bus_width_fifo

Overview:
- Parametrised width-down-converting FIFO; next generation of the 128-to-64-bit bus FIFO.
- Accepts write beats of RATIO narrow words, with a per-beat valid-word count for partial beats.
- Drains one narrow word per read handshake.
- Sits between the wide bus burst interface and the narrow hash-core input. Adds valid/ready handshakes, a level output, an almost-full threshold and a sticky error flag.

Parameters:
RD_W, 64, narrow (read) word width in bits
RATIO, 2, narrow words per write beat; write width = RD_W*RATIO
DEPTH, 32, storage in narrow words; power of 2, >= 2*RATIO
AFULL_THRESH, 24, level at or above which almost_full asserts; 1..DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset; synchronous, active-high
wr_valid  in  1  write beat offered
wr_ready  out  1  FIFO can accept a full beat
wr_data  in  RD_W*RATIO  beat data; word i = bits [i*RD_W +: RD_W], word 0 leaves first
wr_words  in  $clog2(RATIO+1)  number of valid words in the beat, taken from word 0 upward; 0..RATIO
rd_valid  out  1  rd_data holds a valid word
rd_ready  in  1  consumer takes rd_data this cycle
rd_data  out  RD_W  head word, first-word fall-through
level  out  $clog2(DEPTH)+1  number of stored narrow words
almost_full  out  1  level >= AFULL_THRESH
full  out  1  level == DEPTH
empty  out  1  level == 0
err  out  1  sticky illegal-beat flag
clr_err  in  1  clears err

Behaviour:
- Reset (synchronous, rst high at an edge):
  - wr_ptr, rd_ptr, level and err go to 0.
  - Outputs after reset: empty=1, rd_valid=0, full=0, almost_full=0; wr_ready=1 (because DEPTH >= RATIO).
  - Memory contents are not reset; rd_data is don't-care while empty.
  - Reset mid-stream discards all contents. A handshake in the same cycle as rst is ignored.
- Write handshake:
  - A beat is accepted when wr_valid & wr_ready.
  - wr_ready = (DEPTH - level) >= RATIO, registered-state only; no combinational path from wr_valid.
  - Word i (i < wr_words) is stored at mem[(wr_ptr+i) mod DEPTH].
  - wr_ptr advances by wr_words.
  - An accepted beat with wr_words=0 is legal and changes nothing.
- Illegal beat:
  - wr_words > RATIO on an accepted beat drops the entire beat; pointers and level are unchanged.
  - err sets on the next edge and holds until clr_err.
  - If set and clear coincide, set wins.
- Read handshake:
  - rd_valid = !empty.
  - rd_data = mem[rd_ptr], combinational from registered state.
  - On rd_valid & rd_ready, rd_ptr advances by 1 mod DEPTH.
  - rd_ready while empty is ignored; nothing changes and there is no error.
- Latency: a word written at edge N is on rd_data, with rd_valid=1, immediately after edge N.
- Level update: level_next = level + (accepted write ? wr_words : 0) - (accepted read ? 1 : 0).
  - Simultaneous write and read are both honoured in one cycle.
  - A read of the head word while writing into an empty FIFO is impossible, because rd_valid was 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level carries the full/empty distinction.
- full, empty and almost_full are decoded combinationally from level.
- level never exceeds DEPTH. Guaranteed by the wr_ready rule; verification asserts it.

Decomposition:
- Package bus_fifo_pkg holds:
  - localparams PTR_W=$clog2(DEPTH), LVL_W=PTR_W+1, CNT_W=$clog2(RATIO+1);
  - a function word_slice(data, i).
- One sub-module, bus_fifo_mem: RATIO write lanes with per-lane enable and address, one asynchronous read port, RD_W wide, DEPTH entries.
- Pointer, level and flag logic stay in bus_width_fifo.

Test Plan:
- Reset, then one full beat: wr_data={64'hB,64'hA}, wr_words=2 -> level=2. Reads return 64'hA then 64'hB, then empty=1.
- Partial beats: wr_words=1 with {X,64'h1}, then wr_words=2 with {64'h3,64'h2} -> reads return 1,2,3 and level steps 3,2,1,0.
- Fill to 31 words (DEPTH=32):
  - at level 31, wr_ready=0, full=0, almost_full=1;
  - one read gives level 30 and wr_ready=1;
  - a full beat gives level 32 and full=1.
- Wrap-around: stream 100 sequential words with random wr_valid/rd_ready stalls and simultaneous read+write -> output order exact, level matches the model every cycle.
- Illegal beat: wr_words=3 with RATIO=2 -> level unchanged, err=1 the next cycle, err stays set until a clr_err pulse, and a following legal beat still works.
- Reset mid-stream at level 10 -> next cycle level=0, empty=1, wr_ready=1, and a subsequent write is read back correctly.

Source files
------------

// File: rtl/bus_fifo_pkg.sv
// Shared definitions for the width-down-converting bus FIFO.
// - DEF_* : standard configuration (128-bit beats into 64-bit words, 32 words deep)
// - PTR_W, LVL_W, CNT_W : pointer, level and word-count widths of that configuration
// - word_slice : extracts narrow word i (width w) from a wide beat; operates on
//   generously sized vectors so any configuration up to MAX_* can use it
package bus_fifo_pkg;

    localparam int DEF_RD_W         = 64;
    localparam int DEF_RATIO        = 2;
    localparam int DEF_DEPTH        = 32;
    localparam int DEF_AFULL_THRESH = 24;

    localparam int PTR_W = $clog2(DEF_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DEF_RATIO + 1);

    localparam int MAX_RD_W = 256;
    localparam int MAX_WR_W = 1024;

    // Word 0 sits in the least significant bits of the beat.
    function automatic logic [MAX_RD_W-1:0] word_slice(input logic [MAX_WR_W-1:0] data,
                                                       input int unsigned i,
                                                       input int unsigned w);
        logic [MAX_WR_W-1:0] sh;
        logic [MAX_RD_W-1:0] mask;
        sh   = data >> (i * w);
        mask = (MAX_RD_W'(1) << w) - MAX_RD_W'(1);
        return MAX_RD_W'(sh) & mask;
    endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// Narrow-word storage for bus_width_fifo.
// - clk          : write clock
// - we[l]        : write enable for lane l
// - waddr[l]     : entry written by lane l
// - wdata[l]     : word written by lane l
// - raddr/rdata  : asynchronous read port
// Lanes of one beat always target distinct entries, so no write arbitration.
module bus_fifo_mem #(
    parameter int RD_W  = 64,
    parameter int RATIO = 2,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic [RATIO-1:0]           we,
    input  logic [RATIO-1:0][AW-1:0]   waddr,
    input  logic [RATIO-1:0][RD_W-1:0] wdata,
    input  logic [AW-1:0]              raddr,
    output logic [RD_W-1:0]            rdata
);

    logic [RD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int l = 0; l < RATIO; l++) begin
            if (we[l]) mem[waddr[l]] <= wdata[l];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_width_fifo.sv
// Width-down-converting FIFO: takes beats of up to RATIO narrow words and
// drains one narrow word per read handshake, first-word fall-through.
// - clk, rst            : clock, synchronous active-high reset
// - wr_valid/wr_ready   : write beat handshake (ready only when a full beat fits)
// - wr_data, wr_words   : beat payload and number of valid words from word 0 up
// - rd_valid/rd_ready   : read handshake, rd_data is the head word
// - level, full, empty, almost_full : occupancy status
// - err, clr_err        : sticky flag for beats with wr_words > RATIO, and its clear
module bus_width_fifo
    import bus_fifo_pkg::*;
#(
    parameter int RD_W         = DEF_RD_W,
    parameter int RATIO        = DEF_RATIO,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [RD_W*RATIO-1:0]        wr_data,
    input  logic [$clog2(RATIO+1)-1:0]   wr_words,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [RD_W-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         almost_full,
    output logic                         full,
    output logic                         empty,
    output logic                         err,
    input  logic                         clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(RATIO + 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          err_q, err_d;

    logic [LW-1:0] free_words;
    logic          wr_fire, wr_bad, wr_ok, rd_fire;

    logic [RATIO-1:0]           lane_we;
    logic [RATIO-1:0][AW-1:0]   lane_addr;
    logic [RATIO-1:0][RD_W-1:0] lane_data;

    // Ready depends only on stored level, never on wr_valid.
    assign free_words = LW'(DEPTH) - level_q;
    assign wr_ready   = free_words >= LW'(RATIO);

    assign wr_fire = wr_valid && wr_ready && !rst;
    assign wr_bad  = wr_fire && (wr_words > CW'(RATIO));
    assign wr_ok   = wr_fire && !wr_bad;
    assign rd_fire = rd_ready && rd_valid && !rst;

    for (genvar l = 0; l < RATIO; l++) begin : g_lane
        assign lane_we[l]   = wr_ok && (CW'(l) < wr_words);
        assign lane_addr[l] = wr_ptr_q + AW'(l);
        assign lane_data[l] = RD_W'(word_slice(MAX_WR_W'(wr_data), l, RD_W));
    end

    bus_fifo_mem #(
        .RD_W  (RD_W),
        .RATIO (RATIO),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (lane_we),
        .waddr (lane_addr),
        .wdata (lane_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (wr_ok)   wr_ptr_d = wr_ptr_q + AW'(wr_words);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        level_d = level_q + (wr_ok ? LW'(wr_words) : '0) - (rd_fire ? LW'(1) : '0);
        // Set has priority over a coincident clear.
        if (wr_bad)       err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
        err_q    <= err_d;
    end

    assign level       = level_q;
    assign empty       = (level_q == '0);
    assign full        = (level_q == LW'(DEPTH));
    assign almost_full = (level_q >= LW'(AFULL_THRESH));
    assign rd_valid    = !empty;
    assign err         = err_q;

endmodule

// File: tb/tb_bus_width_fifo.sv
module tb_bus_width_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [127:0] wr_data;
    logic [1:0]   wr_words;
    logic         rd_valid;
    logic         rd_ready;
    logic [63:0]  rd_data;
    logic [5:0]   level;
    logic         almost_full;
    logic         full;
    logic         empty;
    logic         err;
    logic         clr_err;

    int n_tests = 0;
    int n_fail  = 0;

    bus_width_fifo dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_words(wr_words),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .almost_full(almost_full), .full(full), .empty(empty),
        .err(err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_beat(input logic [63:0] w1, input logic [63:0] w0, input logic [1:0] n);
        wr_valid = 1'b1;
        wr_data  = {w1, w0};
        wr_words = n;
        tick();
        wr_valid = 1'b0;
        wr_words = 2'd0;
    endtask

    task automatic read_word(input string tag, input logic [63:0] exp);
        check({tag, "_valid"}, 128'(rd_valid), 128'(1));
        check(tag, 128'(rd_data), 128'(exp));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [63:0] q[$];
    int          sent, got_cnt, cyc;
    logic        wv, rr, wf, rf;
    logic [1:0]  nw;
    logic [63:0] nxt;

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_words = '0; rd_ready = 1'b0; clr_err = 1'b0;
        tick();
        do_reset();

        // reset state
        check("rst_level", 128'(level), 128'(0));
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_rd_valid", 128'(rd_valid), 128'(0));
        check("rst_full", 128'(full), 128'(0));
        check("rst_afull", 128'(almost_full), 128'(0));
        check("rst_wr_ready", 128'(wr_ready), 128'(1));
        check("rst_err", 128'(err), 128'(0));

        // one full beat
        write_beat(64'hB, 64'hA, 2'd2);
        check("beat_level", 128'(level), 128'(2));
        read_word("beat_rd0", 64'hA);
        read_word("beat_rd1", 64'hB);
        check("beat_empty", 128'(empty), 128'(1));

        // partial beats
        write_beat(64'hDEAD, 64'h1, 2'd1);
        write_beat(64'h3, 64'h2, 2'd2);
        check("part_level3", 128'(level), 128'(3));
        read_word("part_rd1", 64'h1);
        check("part_level2", 128'(level), 128'(2));
        read_word("part_rd2", 64'h2);
        check("part_level1", 128'(level), 128'(1));
        read_word("part_rd3", 64'h3);
        check("part_level0", 128'(level), 128'(0));

        // fill to 31 words: 15 full beats (100..129) then one partial (130)
        for (int k = 0; k < 15; k++) begin
            write_beat(64'(101 + 2 * k), 64'(100 + 2 * k), 2'd2);
            if (k == 10) check("afull_below", 128'(almost_full), 128'(0));
            if (k == 11) check("afull_at", 128'(almost_full), 128'(1));
        end
        write_beat(64'hDEAD, 64'd130, 2'd1);
        check("fill_level31", 128'(level), 128'(31));
        check("fill_wr_ready31", 128'(wr_ready), 128'(0));
        check("fill_full31", 128'(full), 128'(0));
        check("fill_afull31", 128'(almost_full), 128'(1));
        read_word("fill_rd100", 64'd100);
        check("fill_level30", 128'(level), 128'(30));
        check("fill_wr_ready30", 128'(wr_ready), 128'(1));
        write_beat(64'd132, 64'd131, 2'd2);
        check("fill_level32", 128'(level), 128'(32));
        check("fill_full32", 128'(full), 128'(1));
        check("fill_wr_ready32", 128'(wr_ready), 128'(0));
        for (int k = 101; k <= 132; k++) read_word("fill_drain", 64'(k));
        check("drain_empty", 128'(empty), 128'(1));

        // read while empty is ignored
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("empty_rd_level", 128'(level), 128'(0));
        check("empty_rd_err", 128'(err), 128'(0));

        // streaming with random stalls against a queue model
        sent = 0; got_cnt = 0; cyc = 0; nxt = 64'd1000;
        while (got_cnt < 100 && cyc < 5000) begin
            wv = ($urandom_range(0, 3) != 0) && (sent < 100);
            nw = 2'($urandom_range(0, 2));
            if (sent + int'(nw) > 100) nw = 2'(100 - sent);
            rr = ($urandom_range(0, 2) != 0);
            wr_valid = wv;
            wr_words = nw;
            wr_data  = {nxt + 64'd1, nxt};
            rd_ready = rr;
            check("strm_wr_ready", 128'(wr_ready), 128'((32 - q.size()) >= 2));
            check("strm_rd_valid", 128'(rd_valid), 128'(q.size() != 0));
            if (q.size() != 0) check("strm_rd_data", 128'(rd_data), 128'(q[0]));
            wf = wv && ((32 - q.size()) >= 2);
            rf = rr && (q.size() != 0);
            tick();
            if (rf) begin
                void'(q.pop_front());
                got_cnt++;
            end
            if (wf) begin
                for (int i = 0; i < int'(nw); i++) q.push_back(nxt + 64'(i));
                nxt  = nxt + 64'(nw);
                sent = sent + int'(nw);
            end
            check("strm_level", 128'(level), 128'(q.size()));
            check("strm_level_max", 128'(level <= 6'd32), 128'(1));
            cyc++;
        end
        wr_valid = 1'b0; rd_ready = 1'b0; wr_words = 2'd0;
        check("strm_done", 128'(got_cnt), 128'(100));
        check("strm_last", 128'(nxt), 128'(64'd1100));

        // illegal beat
        write_beat(64'hDEAD, 64'h7, 2'd1);
        write_beat(64'hEE, 64'hFF, 2'd3);
        check("ill_level", 128'(level), 128'(1));
        check("ill_err", 128'(err), 128'(1));
        tick();
        tick();
        check("ill_err_hold", 128'(err), 128'(1));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ill_err_clr", 128'(err), 128'(0));
        clr_err = 1'b1;
        write_beat(64'hEE, 64'hFF, 2'd3);
        clr_err = 1'b0;
        check("ill_set_wins", 128'(err), 128'(1));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ill_err_clr2", 128'(err), 128'(0));
        write_beat(64'h9, 64'h8, 2'd2);
        check("ill_after_level", 128'(level), 128'(3));
        read_word("ill_rd7", 64'h7);
        read_word("ill_rd8", 64'h8);
        read_word("ill_rd9", 64'h9);

        // reset mid-stream at level 10, with a write offered in the reset cycle
        for (int k = 0; k < 5; k++) write_beat(64'(2 * k + 1), 64'(2 * k), 2'd2);
        check("mid_level10", 128'(level), 128'(10));
        rst = 1'b1;
        write_beat(64'h44, 64'h33, 2'd2);
        rst = 1'b0;
        check("mid_level0", 128'(level), 128'(0));
        check("mid_empty", 128'(empty), 128'(1));
        check("mid_wr_ready", 128'(wr_ready), 128'(1));
        write_beat(64'hDEAD, 64'h55, 2'd1);
        check("mid_level1", 128'(level), 128'(1));
        read_word("mid_rd55", 64'h55);
        check("mid_empty_end", 128'(empty), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
